// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: latches a request, drives the ALU for EXEC_CYCLES, returns the captured result.
// Latency: accept -> response valid after EXEC_CYCLES+1 edges (1 edge for illegal opcodes); request and response channels are valid/ready.
// Backpressure: req_ready is low outside IDLE; a stalled response holds all rsp_* stable until rsp_ready.
module alu_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 4,
    parameter int TAG_W       = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [15:0]       op_count
);

    localparam int CNT_W = 4;
    localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_W'(5);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              alu_enable_q, alu_enable_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] alu_src1_q, alu_src1_d;
    logic [DATA_W-1:0] alu_src2_q, alu_src2_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_overflow_q, rsp_overflow_d;
    logic              rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [15:0]       op_count_q, op_count_d;

    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        alu_enable_d   = alu_enable_q;
        alu_op_d       = alu_op_q;
        alu_src1_d     = alu_src1_q;
        alu_src2_d     = alu_src2_q;
        tag_d          = tag_q;
        cnt_d          = cnt_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        rsp_tag_d      = rsp_tag_q;
        op_count_d     = op_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_op_d    = req_op;
                    alu_src1_d  = req_src1;
                    alu_src2_d  = req_src2;
                    tag_d       = req_tag;
                    req_ready_d = 1'b0;
                    if (req_op <= OP_LAST_LEGAL) begin
                        state_d      = EXEC;
                        alu_enable_d = 1'b1;
                        cnt_d        = CNT_W'(EXEC_CYCLES - 1);
                    end else begin
                        // Illegal opcode: answer straight away, ALU stays idle.
                        state_d        = RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_err_d      = 1'b1;
                        rsp_result_d   = '0;
                        rsp_overflow_d = 1'b0;
                        rsp_tag_d      = req_tag;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d        = RESP;
                    alu_enable_d   = 1'b0;
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = alu_result;
                    rsp_overflow_d = alu_overflow;
                    rsp_err_d      = 1'b0;
                    rsp_tag_d      = tag_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                alu_enable_d = 1'b0;
                rsp_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            alu_enable_q   <= 1'b0;
            alu_op_q       <= '0;
            alu_src1_q     <= '0;
            alu_src2_q     <= '0;
            tag_q          <= '0;
            cnt_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_tag_q      <= '0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            alu_enable_q   <= alu_enable_d;
            alu_op_q       <= alu_op_d;
            alu_src1_q     <= alu_src1_d;
            alu_src2_q     <= alu_src2_d;
            tag_q          <= tag_d;
            cnt_q          <= cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
            rsp_tag_q      <= rsp_tag_d;
            op_count_q     <= op_count_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign alu_enable   = alu_enable_q;
    assign alu_op       = alu_op_q;
    assign alu_src1     = alu_src1_q;
    assign alu_src2     = alu_src2_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_tag      = rsp_tag_q;
    assign op_count     = op_count_q;

endmodule
